// File: rtl/bcd_digit_accum_if.sv
// rtl/bcd_digit_accum_if.sv - keypad entry / operand result bundle for bcd_digit_accum
interface bcd_digit_accum_if #(
    parameter int NDIG = 4,
    parameter int W    = 14
);
    logic                key_valid;
    logic [3:0]          key_code;
    logic                enter;
    logic                clr;
    logic                ready;
    logic [4*NDIG-1:0]   bcd_digits;
    logic [2:0]          ndig;
    logic [W-1:0]        bin_out;
    logic                bin_valid;
    logic                err;

    modport master (
        output key_valid, key_code, enter, clr,
        input  ready, bcd_digits, ndig, bin_out, bin_valid, err
    );

    modport slave (
        input  key_valid, key_code, enter, clr,
        output ready, bcd_digits, ndig, bin_out, bin_valid, err
    );
endinterface

// File: rtl/bcd_digit_accum.sv
// rtl/bcd_digit_accum.sv - BCD keypad entry register with sequential BCD-to-binary conversion
module bcd_digit_accum #(
    parameter int NDIG = 4,
    parameter int W    = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_digit_accum_if.slave     bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

    state_t              state;
    logic [4*NDIG-1:0]   digits;
    logic [2:0]          ndig;
    logic [W-1:0]        acc;
    logic [IW-1:0]       idx;
    logic [W-1:0]        bin_out;
    logic                bin_valid;
    logic                err;
    logic [3:0]          cur_digit;
    logic [W-1:0]        acc_next;

    // acc*10 + digit as shift-add; cannot overflow given 10^NDIG-1 < 2^W
    always_comb begin
        cur_digit = 4'(digits >> {idx, 2'b00});
        acc_next  = (acc << 3) + (acc << 1) + W'(cur_digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTRY;
            digits    <= '0;
            ndig      <= '0;
            acc       <= '0;
            idx       <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= 1'b0;
            bin_valid <= 1'b0;
            if (bus.clr) begin
                state   <= ENTRY;
                digits  <= '0;
                ndig    <= '0;
                acc     <= '0;
                idx     <= '0;
                bin_out <= '0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (bus.enter) begin
                            if (bus.key_valid) err <= 1'b1;
                            if (ndig != 3'd0) begin
                                acc   <= '0;
                                idx   <= IW'(NDIG - 1);
                                state <= CONV;
                            end else begin
                                bin_out   <= '0;
                                bin_valid <= 1'b1;
                            end
                        end else if (bus.key_valid) begin
                            if (bus.key_code <= 4'd9 && ndig < 3'(NDIG)) begin
                                digits <= {digits[4*NDIG-5:0], bus.key_code};
                                ndig   <= ndig + 3'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    CONV: begin
                        if (bus.key_valid || bus.enter) err <= 1'b1;
                        acc <= acc_next;
                        idx <= idx - IW'(1);
                        // publish on the last digit so bin_valid is high during DONE
                        if (idx == '0) begin
                            state     <= DONE;
                            bin_out   <= acc_next;
                            bin_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (bus.key_valid || bus.enter) err <= 1'b1;
                        digits <= '0;
                        ndig   <= '0;
                        state  <= ENTRY;
                    end
                    default: state <= ENTRY;
                endcase
            end
        end
    end

    assign bus.ready      = (state == ENTRY);
    assign bus.bcd_digits = digits;
    assign bus.ndig       = ndig;
    assign bus.bin_out    = bin_out;
    assign bus.bin_valid  = bin_valid;
    assign bus.err        = err;
endmodule
